// File: rtl/airlock_controller_if.sv
// airlock_controller_if
//   Bundles the airlock's board switches and indicator outputs.
//   Modports:
//     master - the switch side (board / tester): drives SW0..SW3, reads indicators
//     slave  - the controller: reads SW0..SW3, drives indicators
//   Signals:
//     SW0           evacuate request (rising edge requests evacuation)
//     SW1           pressurize request (rising edge requests pressurization)
//     SW2           outer (vacuum-side) door command, level
//     SW3           inner (pressurized-side) door command, level
//     OuterDoorOpen, InnerDoorOpen, PumpOn, ValveOn, Pressurized, Fault
//     Countdown[3:0] cycles remaining in the current timed phase, 0 otherwise
//
// Handshake semantics: there is no valid/ready pair on this bus. Every switch
// is a level that the controller samples on each rising clock edge, and every
// indicator is a registered level that is valid for the whole cycle after the
// edge that produced it.
interface airlock_controller_if;
    logic       SW0;
    logic       SW1;
    logic       SW2;
    logic       SW3;
    logic       OuterDoorOpen;
    logic       InnerDoorOpen;
    logic       PumpOn;
    logic       ValveOn;
    logic       Pressurized;
    logic       Fault;
    logic [3:0] Countdown;

    modport master (
        output SW0, SW1, SW2, SW3,
        input  OuterDoorOpen, InnerDoorOpen, PumpOn, ValveOn, Pressurized,
               Fault, Countdown
    );

    modport slave (
        input  SW0, SW1, SW2, SW3,
        output OuterDoorOpen, InnerDoorOpen, PumpOn, ValveOn, Pressurized,
               Fault, Countdown
    );
endinterface

// File: rtl/airlock_controller.sv
// airlock_controller
//   Two-door airlock interlock. Sequences the chamber between pressurized
//   and vacuum through timed evacuation and fill phases, and only lets a door
//   open when the chamber matches that door's side.
//   Parameters:
//     EVAC_CYCLES  - cycles spent evacuating (1..15)
//     PRESS_CYCLES - cycles spent pressurizing (1..15)
//   Ports:
//     Clock     - system clock, rising edge
//     Key0      - asynchronous active-low reset
//     bus       - airlock_controller_if.slave (switches in, indicators out)
//     state_dbg - current FSM state (0 PRESS, 1 EVACUATING, 2 VACUUM,
//                 3 PRESSURIZING) for observation
//   Build option:
//     INTERLOCK_ABORT_EN - when defined, a pressurize request during
//     evacuation (or an evacuate request during pressurization) reverses the
//     phase immediately. When undefined, requests during a timed phase are
//     ignored.
module airlock_controller #(
    parameter int EVAC_CYCLES  = 8,
    parameter int PRESS_CYCLES = 5
) (
    input  logic                Clock,
    input  logic                Key0,
    airlock_controller_if.slave bus,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        ST_PRESS        = 2'd0,
        ST_EVACUATING   = 2'd1,
        ST_VACUUM       = 2'd2,
        ST_PRESSURIZING = 2'd3
    } state_t;

    localparam logic [3:0] EVAC_LOAD  = 4'(EVAC_CYCLES);
    localparam logic [3:0] PRESS_LOAD = 4'(PRESS_CYCLES);

    state_t     state;
    state_t     state_next;
    // The phase counter doubles as the Countdown output: it is loaded on entry
    // to a timed phase and cleared on leaving one, so it is 0 elsewhere.
    logic [3:0] count;
    logic [3:0] count_next;

    logic sw0_q;
    logic sw1_q;
    logic evac_edge;
    logic press_edge;
    logic doors_closed;
    logic fault_next;

    logic outer_q;
    logic inner_q;
    logic pump_q;
    logic valve_q;
    logic press_q;
    logic fault_q;

    assign evac_edge    = bus.SW0 & ~sw0_q;
    assign press_edge   = bus.SW1 & ~sw1_q;
    // A request edge seen while either door switch is high is simply lost.
    assign doors_closed = ~bus.SW2 & ~bus.SW3;

    always_comb begin
        state_next = state;
        count_next = count;
        unique case (state)
            ST_PRESS: begin
                if (evac_edge && doors_closed) begin
                    state_next = ST_EVACUATING;
                    count_next = EVAC_LOAD;
                end
            end
            ST_EVACUATING: begin
`ifdef INTERLOCK_ABORT_EN
                if (press_edge && doors_closed) begin
                    state_next = ST_PRESSURIZING;
                    count_next = PRESS_LOAD;
                end else
`endif
                if (count == 4'd1) begin
                    state_next = ST_VACUUM;
                    count_next = 4'd0;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            ST_VACUUM: begin
                if (press_edge && doors_closed) begin
                    state_next = ST_PRESSURIZING;
                    count_next = PRESS_LOAD;
                end
            end
            ST_PRESSURIZING: begin
`ifdef INTERLOCK_ABORT_EN
                if (evac_edge && doors_closed) begin
                    state_next = ST_EVACUATING;
                    count_next = EVAC_LOAD;
                end else
`endif
                if (count == 4'd1) begin
                    state_next = ST_PRESS;
                    count_next = 4'd0;
                end else begin
                    count_next = count - 4'd1;
                end
            end
        endcase
    end

    // Door outputs and Fault are judged against the state being entered at
    // this edge, together with the door switches sampled at the same edge.
    always_comb begin
        fault_next = 1'b0;
        unique case (state_next)
            ST_PRESS:        fault_next = bus.SW2;
            ST_VACUUM:       fault_next = bus.SW3;
            ST_EVACUATING:   fault_next = bus.SW2 | bus.SW3;
            ST_PRESSURIZING: fault_next = bus.SW2 | bus.SW3;
        endcase
    end

    always_ff @(posedge Clock or negedge Key0) begin
        if (!Key0) begin
            state   <= ST_PRESS;
            count   <= 4'd0;
            sw0_q   <= 1'b0;
            sw1_q   <= 1'b0;
            outer_q <= 1'b0;
            inner_q <= 1'b0;
            pump_q  <= 1'b0;
            valve_q <= 1'b0;
            press_q <= 1'b1;
            fault_q <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            sw0_q   <= bus.SW0;
            sw1_q   <= bus.SW1;
            outer_q <= (state_next == ST_VACUUM) & bus.SW2;
            inner_q <= (state_next == ST_PRESS) & bus.SW3;
            pump_q  <= (state_next == ST_EVACUATING);
            valve_q <= (state_next == ST_PRESSURIZING);
            press_q <= (state_next == ST_PRESS);
            fault_q <= fault_next;
        end
    end

    assign bus.OuterDoorOpen = outer_q;
    assign bus.InnerDoorOpen = inner_q;
    assign bus.PumpOn        = pump_q;
    assign bus.ValveOn       = valve_q;
    assign bus.Pressurized   = press_q;
    assign bus.Fault         = fault_q;
    assign bus.Countdown     = count;
    assign state_dbg         = state;

endmodule
